key_note_arbiter: RTL and testbench



---
 rtl/epiano_pkg.sv | 15 +
 rtl/prio_enc.sv | 21 ++
 rtl/key_note_arbiter.sv | 114 +++++++++++
 tb/tb_key_note_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/epiano_pkg.sv
// Shared types and constants for the ePiano key-to-tone control path.
package epiano_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    TAIL = 2'd2
  } state_t;

  // Debouncer outputs are active-low: a pressed key reads as 0.
  localparam logic KEY_ACTIVE = 1'b0;

  localparam int TIMER_W = 20;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit encoder: idx is the lowest index with vec[idx]=1, any flags a non-empty vector.
module prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan downward so the lowest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/key_note_arbiter.sv
// Picks which debounced key drives the single tone generator: newest press wins,
// release falls back to a held key, last release holds a fixed tail.
//
// state | meaning
// IDLE  | no key held, tail expired, tone generator off
// PLAY  | at least one key held, note_idx names the sounding key
// TAIL  | all keys released, note held on while the tail timer runs
module key_note_arbiter
  import epiano_pkg::*;
#(
  parameter int N_KEYS     = 8,
  parameter int IDX_W      = 3,
  parameter int TAIL_TICKS = 50000
) (
  input  logic              clk1M,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [IDX_W-1:0]  note_idx,
  output logic              note_on,
  output logic              note_start
);

  localparam logic [TIMER_W-1:0] TAIL_LAST = TIMER_W'(TAIL_TICKS - 1);

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [N_KEYS-1:0]   pressed, pressed_q, press_evt;
  logic [IDX_W-1:0]    evt_idx, held_idx, idx_d;
  logic                evt_any, held_any, cur_held;
  logic                on_d, start_d;

  assign pressed   = key_n ^ {N_KEYS{~KEY_ACTIVE}};
  assign press_evt = pressed & ~pressed_q;
  assign cur_held  = pressed[note_idx];

  prio_enc #(.N(N_KEYS), .IDX_W(IDX_W)) u_evt_enc (
    .vec (press_evt),
    .idx (evt_idx),
    .any (evt_any)
  );

  prio_enc #(.N(N_KEYS), .IDX_W(IDX_W)) u_held_enc (
    .vec (pressed),
    .idx (held_idx),
    .any (held_any)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = note_idx;
    on_d    = note_on;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        on_d = 1'b0;
        if (evt_any) begin
          idx_d   = evt_idx;
          on_d    = 1'b1;
          start_d = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        // A fresh press outranks a release landing on the same edge.
        if (evt_any) begin
          idx_d   = evt_idx;
          start_d = 1'b1;
        end else if (!cur_held && held_any) begin
          idx_d   = held_idx;
          start_d = 1'b1;
        end else if (!held_any) begin
          timer_d = '0;
          state_d = TAIL;
        end
      end
      TAIL: begin
        if (evt_any) begin
          idx_d   = evt_idx;
          start_d = 1'b1;
          state_d = PLAY;
        end else if (timer_q == TAIL_LAST) begin
          on_d    = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        on_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pressed_q  <= '0;
      note_idx   <= '0;
      note_on    <= 1'b0;
      note_start <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pressed_q  <= pressed;
      note_idx   <= idx_d;
      note_on    <= on_d;
      note_start <= start_d;
    end
  end

endmodule

// File: tb/tb_key_note_arbiter.sv
// Directed bench for key_note_arbiter; tail shortened so the whole run stays small.
module tb_key_note_arbiter;

  localparam int N    = 8;
  localparam int W    = 3;
  localparam int TAIL = 5000;
  localparam int MID  = 3000;

  logic         clk1M = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_n = '1;
  logic [W-1:0] note_idx;
  logic         note_on;
  logic         note_start;

  int total = 0;
  int bad   = 0;

  key_note_arbiter #(.N_KEYS(N), .IDX_W(W), .TAIL_TICKS(TAIL)) dut (
    .clk1M      (clk1M),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .note_idx   (note_idx),
    .note_on    (note_on),
    .note_start (note_start)
  );

  always #5 clk1M = ~clk1M;

  task automatic step();
    @(posedge clk1M);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] idx,
                            input logic on, input logic start);
    total++;
    if (note_idx !== idx || note_on !== on || note_start !== start) begin
      bad++;
      $display("FAIL %s: got idx=%0d on=%b start=%b, want idx=%0d on=%b start=%b",
               name, note_idx, note_on, note_start, idx, on, start);
    end
  endtask

  task automatic do_reset();
    key_n = '1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    key_n = '1;
    rst_n = 1'b0;
    #3;
    total++;
    if (note_idx !== 3'd0 || note_on !== 1'b0 || note_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: got idx=%0d on=%b start=%b, want 0 0 0",
               note_idx, note_on, note_start);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    total++;
    if (note_on !== 1'b0 || note_start !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet: got on=%b start=%b, want 0 0", note_on, note_start);
    end
  endtask

  task automatic test_single_and_tail();
    int drops;
    key_n = 8'b1101_1111;
    step();
    expect_out("press5", 3'd5, 1'b1, 1'b1);
    step();
    expect_out("press5_hold", 3'd5, 1'b1, 1'b0);
    key_n = '1;
    step();
    expect_out("release5_tail_entry", 3'd5, 1'b1, 1'b0);
    drops = 0;
    for (int i = 1; i < TAIL; i++) begin
      step();
      if (note_on !== 1'b1 || note_start !== 1'b0) drops++;
    end
    total++;
    if (drops != 0) begin
      bad++;
      $display("FAIL tail_held: got %0d bad tail cycles, want 0", drops);
    end
    step();
    expect_out("tail_expire", 3'd5, 1'b0, 1'b0);
    step();
    expect_out("idle_after_tail", 3'd5, 1'b0, 1'b0);
  endtask

  task automatic test_fallback();
    do_reset();
    key_n = ~8'h04;
    step();
    expect_out("hold2", 3'd2, 1'b1, 1'b1);
    step();
    key_n = ~8'h44;
    step();
    expect_out("press6_over2", 3'd6, 1'b1, 1'b1);
    step();
    expect_out("press6_steady", 3'd6, 1'b1, 1'b0);
    key_n = ~8'h04;
    step();
    expect_out("release6_back2", 3'd2, 1'b1, 1'b1);
    step();
    key_n = '1;
    step();
    expect_out("release2_tail", 3'd2, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    int drops;
    do_reset();
    key_n = ~8'h12;
    step();
    expect_out("keys1_4_low", 3'd1, 1'b1, 1'b1);
    step();
    key_n = ~8'h10;
    step();
    expect_out("release1_to4", 3'd4, 1'b1, 1'b1);
    step();
    key_n = ~8'h80;
    step();
    expect_out("release4_press7", 3'd7, 1'b1, 1'b1);
    drops = 0;
    for (int i = 0; i < TAIL + 5; i++) begin
      step();
      if (note_on !== 1'b1 || note_start !== 1'b0 || note_idx !== 3'd7) drops++;
    end
    total++;
    if (drops != 0) begin
      bad++;
      $display("FAIL key7_stays_play: got %0d bad cycles, want 0", drops);
    end
  endtask

  task automatic test_tail_interrupt();
    int drops;
    key_n = '1;
    step();
    drops = 0;
    for (int i = 0; i < MID; i++) begin
      step();
      if (note_on !== 1'b1) drops++;
    end
    key_n = ~8'h08;
    step();
    expect_out("tail_mid_press3", 3'd3, 1'b1, 1'b1);
    total++;
    if (drops != 0) begin
      bad++;
      $display("FAIL tail_mid_on: got %0d off cycles, want 0", drops);
    end
    step();
    key_n = '1;
    step();
    drops = 0;
    for (int i = 1; i < TAIL; i++) begin
      step();
      if (note_on !== 1'b1) drops++;
    end
    key_n = ~8'h08;
    step();
    expect_out("tail_expiry_press3", 3'd3, 1'b1, 1'b1);
    total++;
    if (drops != 0) begin
      bad++;
      $display("FAIL tail_expiry_on: got %0d off cycles, want 0", drops);
    end
  endtask

  task automatic test_back_to_back();
    key_n = ~8'h09;
    step();
    expect_out("b2b_press0", 3'd0, 1'b1, 1'b1);
    key_n = ~8'h0B;
    step();
    expect_out("b2b_press1", 3'd1, 1'b1, 1'b1);
    step();
    expect_out("b2b_settle", 3'd1, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    key_n = ~8'h40;
    step();
    expect_out("pre_reset_play", 3'd6, 1'b1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset_clear", 3'd0, 1'b0, 1'b0);
    key_n = ~8'h01;
    step();
    expect_out("reset_held_no_start", 3'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    expect_out("held_key0_after_reset", 3'd0, 1'b1, 1'b1);
    step();
    expect_out("held_key0_steady", 3'd0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_and_tail();
    test_fallback();
    test_simultaneous();
    test_tail_interrupt();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
